// File: rtl/softmax_pkg.sv
// Shared formats, constants and helpers for the softmax exp stage.
// Inputs are signed Q8.8 and outputs are unsigned Q1.15.
package softmax_pkg;

  localparam int DW        = 16;
  localparam int IN_FRAC   = 8;
  localparam int OUT_FRAC  = 15;
  localparam logic [DW-1:0] EXP_ONE = 16'h8000;

  // log2(e) ~= 1 + 1/2 - 1/16, applied as two arithmetic shift taps
  localparam int LOG2E_SH1 = 1;
  localparam int LOG2E_SH2 = 4;

  localparam int DIFF_W  = DW + 1;
  localparam int SCL_W   = DW + 3;
  localparam int U_W     = DW + 2;
  localparam int K_W     = U_W - IN_FRAC;
  localparam int SH_W    = $clog2(DW);
  // 2^-f ~= 1 - f/2, so the Q.8 fraction lands one bit below the Q1.15 unit
  localparam int MANT_SH = OUT_FRAC - IN_FRAC - 1;

  localparam int MAX_LEN = 13;
  localparam int LEN_W   = 4;

  typedef struct packed {
    logic             first;
    logic             last;
    logic [LEN_W-1:0] len_mode;
  } beat_tag_t;

  function automatic logic [LEN_W-1:0] decode_len(input logic [LEN_W-1:0] mode);
    if (mode == '0 || mode > LEN_W'(MAX_LEN)) return LEN_W'(1);
    return mode;
  endfunction

endpackage

// File: rtl/exp2_lane.sv
// One lane of the base-2 exponential: d = x - M, scale by log2(e), then
// split into shift count and linear mantissa. Two registered stages.
module exp2_lane
  import softmax_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_max,
  output logic        [DW-1:0] o_exp
);

  // A positive difference means the max was mis-aligned; treat it as x == M.
  function automatic logic signed [DIFF_W-1:0] clamp_nonpos(
    input logic signed [DIFF_W-1:0] d
  );
    return (d > 0) ? '0 : d;
  endfunction

  function automatic logic [DW-1:0] exp2_shift(input logic [U_W-1:0] u);
    logic [K_W-1:0]     k;
    logic [IN_FRAC-1:0] f;
    logic [DW-1:0]      m;
    k = u[U_W-1:IN_FRAC];
    f = u[IN_FRAC-1:0];
    m = EXP_ONE - (DW'(f) << MANT_SH);
    if (k < K_W'(DW)) return m >> k[SH_W-1:0];
    return '0;
  endfunction

  logic signed [DIFF_W-1:0] diff;
  logic signed [SCL_W-1:0]  dext;
  logic signed [SCL_W-1:0]  scaled;
  logic        [U_W-1:0]    u_next;

  always_comb begin
    diff   = clamp_nonpos(DIFF_W'(i_x) - DIFF_W'(i_max));
    dext   = SCL_W'(diff);
    scaled = dext + (dext >>> LOG2E_SH1) - (dext >>> LOG2E_SH2);
    u_next = U_W'(-scaled);
  end

  logic [U_W-1:0] u_p1;
  logic [DW-1:0]  exp_p2;

  // ---- S1: scaled magnitude | S2: shifted mantissa ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      u_p1   <= '0;
      exp_p2 <= '0;
    end else if (i_en) begin
      u_p1   <= u_next;
      exp_p2 <= exp2_shift(u_p1);
    end
  end

  assign o_exp = exp_p2;

endmodule

// File: rtl/sub_max_exp2.sv
// Softmax exp stage: per-lane 2^(log2e * (x - M)) plus a per-group sum of
// all lane exponentials for the downstream normalise stage.
module sub_max_exp2 #(
  parameter int LANES = 64,
  parameter int DW    = 16,
  parameter int SUMW  = 26
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic signed [DW-1:0]   i_global_max,
  input  logic [3:0]             i_length_mode,
  input  logic [LANES*DW-1:0]    i_in_flat,
  output logic                   o_valid,
  output logic [LANES*DW-1:0]    o_exp_flat,
  output logic [3:0]             o_length_mode_byp,
  output logic                   o_last,
  output logic                   o_sum_valid,
  output logic [SUMW-1:0]        o_sum
);
  import softmax_pkg::*;

  localparam int BSW = DW + $clog2(LANES);

  // Group length is only sampled on the first beat; later beats reuse n_lat.
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] n_lat;
  logic [LEN_W-1:0] n_eff;
  logic             first_in;
  logic             last_in;
  beat_tag_t        tag_in;

  always_comb begin
    first_in = (cnt == '0);
    n_eff    = first_in ? decode_len(i_length_mode) : n_lat;
    last_in  = (cnt == n_eff - LEN_W'(1));
    tag_in   = '{first: first_in, last: i_valid && last_in, len_mode: i_length_mode};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      n_lat <= '0;
    end else if (i_en && i_valid) begin
      if (first_in) n_lat <= n_eff;
      cnt <= last_in ? '0 : cnt + LEN_W'(1);
    end
  end

  logic [DW-1:0] exp_p2 [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exp2_lane u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_en),
      .i_x   (i_in_flat[DW*g +: DW]),
      .i_max (i_global_max),
      .o_exp (exp_p2[g])
    );
  end

  logic      vld_p1, vld_p2, vld_p3;
  beat_tag_t tag_p1, tag_p2, tag_p3;

  // ---- S1/S2: control rides alongside the lane datapath ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      tag_p1 <= '0;
      tag_p2 <= '0;
    end else if (i_en) begin
      vld_p1 <= i_valid;
      vld_p2 <= vld_p1;
      tag_p1 <= tag_in;
      tag_p2 <= tag_p1;
    end
  end

  logic [BSW-1:0] node [2*LANES-1];
  logic [BSW-1:0] beat_sum;

  // Heap-indexed adder tree: leaves at LANES-1.., node i sums 2i+1 and 2i+2.
  always_comb begin
    for (int i = 0; i < LANES; i++) node[LANES-1+i] = BSW'(exp_p2[i]);
    for (int i = LANES - 2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    beat_sum = node[0];
  end

  logic [BSW-1:0] beat_sum_p3;

  // ---- S3: presented exponentials and beat sum ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p3      <= 1'b0;
      tag_p3      <= '0;
      o_exp_flat  <= '0;
      beat_sum_p3 <= '0;
    end else if (i_en) begin
      vld_p3      <= vld_p2;
      tag_p3      <= tag_p2;
      beat_sum_p3 <= beat_sum;
      for (int i = 0; i < LANES; i++) o_exp_flat[DW*i +: DW] <= exp_p2[i];
    end
  end

  assign o_valid           = vld_p3;
  assign o_last            = tag_p3.last;
  assign o_length_mode_byp = tag_p3.len_mode;

  logic [SUMW-1:0] acc;
  logic [SUMW-1:0] acc_next;

  always_comb acc_next = (tag_p3.first ? '0 : acc) + SUMW'(beat_sum_p3);

  // ---- S4: group accumulator ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc         <= '0;
      o_sum       <= '0;
      o_sum_valid <= 1'b0;
    end else if (i_en) begin
      o_sum_valid <= vld_p3 && tag_p3.last;
      if (vld_p3) begin
        acc <= acc_next;
        if (tag_p3.last) o_sum <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_sub_max_exp2.sv
// Directed bench for sub_max_exp2: lane patterns with hand-computed
// exponentials, scoreboarded beats and group sums.
module tb_sub_max_exp2;

  localparam int LANES = 64;
  localparam int DW    = 16;
  localparam int SUMW  = 26;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   valid;
  logic signed [DW-1:0]   gmax;
  logic [3:0]             lmode;
  logic [LANES*DW-1:0]    in_flat;
  logic                   o_valid;
  logic [LANES*DW-1:0]    o_exp_flat;
  logic [3:0]             o_length_mode_byp;
  logic                   o_last;
  logic                   o_sum_valid;
  logic [SUMW-1:0]        o_sum;

  always #5 clk = ~clk;

  sub_max_exp2 #(.LANES(LANES), .DW(DW), .SUMW(SUMW)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_en              (en),
    .i_valid           (valid),
    .i_global_max      (gmax),
    .i_length_mode     (lmode),
    .i_in_flat         (in_flat),
    .o_valid           (o_valid),
    .o_exp_flat        (o_exp_flat),
    .o_length_mode_byp (o_length_mode_byp),
    .o_last            (o_last),
    .o_sum_valid       (o_sum_valid),
    .o_sum             (o_sum)
  );

  // Lane i uses column i%4. Patterns: all 0, all -1.0, all -16.0, all +5 lsb
  // (clamped), mixed {0, -0.5, -2.0, -1 lsb}.
  int dtab [5][4] = '{'{0, 0, 0, 0}, '{-256, -256, -256, -256},
                      '{-4096, -4096, -4096, -4096}, '{5, 5, 5, 5},
                      '{0, -128, -512, -1}};
  int etab [5][4] = '{'{32768, 32768, 32768, 32768}, '{12800, 12800, 12800, 12800},
                      '{0, 0, 0, 0}, '{32768, 32768, 32768, 32768},
                      '{32768, 20992, 4608, 32704}};

  typedef struct {
    int pat;
    bit last;
    int lm;
  } beat_t;

  beat_t  exp_beats [$];
  longint exp_sums  [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  logic en_q = 1'b0;
  always @(posedge clk) en_q <= en;

  always @(negedge clk) begin
    beat_t b;
    int    nb;
    if (en_q && o_valid) begin
      if (exp_beats.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        b  = exp_beats.pop_front();
        nb = 0;
        for (int i = 0; i < LANES; i++)
          if (o_exp_flat[DW*i +: DW] !== 16'(etab[b.pat][i%4])) nb++;
        check("exp_lanes_wrong", nb, 0);
        check("exp_lane1", o_exp_flat[2*DW-1:DW], etab[b.pat][1]);
        check("last", o_last, b.last);
        check("lmode_byp", o_length_mode_byp, b.lm);
      end
    end
    if (en_q && o_sum_valid) begin
      if (exp_sums.size() == 0) check("unexpected_sum", 1, 0);
      else check("group_sum", o_sum, exp_sums.pop_front());
    end
  end

  task automatic scramble();
    for (int i = 0; i < LANES; i++) in_flat[DW*i +: DW] = 16'($urandom);
    lmode = 4'($urandom);
  endtask

  task automatic beat(input int p, input int lm, input bit last, input bit keep = 1'b1);
    @(negedge clk);
    rst   = 1'b0;
    en    = 1'b1;
    valid = 1'b1;
    lmode = 4'(lm);
    for (int i = 0; i < LANES; i++)
      in_flat[DW*i +: DW] = 16'(int'(gmax) + dtab[p][i%4]);
    if (keep) exp_beats.push_back('{p, last, lm});
  endtask

  task automatic bubble();
    @(negedge clk);
    rst   = 1'b0;
    en    = 1'b1;
    valid = 1'b0;
    scramble();
  endtask

  task automatic stall();
    @(negedge clk);
    en    = 1'b0;
    valid = 1'b1;
    scramble();
  endtask

  task automatic drain(input int n);
    repeat (n) bubble();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_sum_valid"}, o_sum_valid, 0);
    check({tag, "_sum"}, o_sum, 0);
    check({tag, "_exp_any"}, |o_exp_flat, 0);
    check({tag, "_lmode"}, o_length_mode_byp, 0);
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    valid   = 1'b0;
    gmax    = 16'sh0500;
    lmode   = '0;
    in_flat = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Single N=1 beat of x == M: exact latency 3 for data, 4 for the sum.
    beat(0, 1, 1'b1);
    exp_sums.push_back(2097152);
    bubble(); check("lat_valid_c1", o_valid, 0);
    bubble(); check("lat_valid_c2", o_valid, 0);
    bubble(); check("lat_valid_c3", o_valid, 1); check("lat_sumv_c3", o_sum_valid, 0);
    bubble(); check("lat_sumv_c4", o_sum_valid, 1); check("lat_sum_c4", o_sum, 2097152);
    check("lat_valid_c4", o_valid, 0);
    bubble(); check("lat_sumv_c5", o_sum_valid, 0);

    // Back-to-back N=1 groups with a negative max: -1.0, -16.0, clamp.
    gmax = -16'sh0200;
    beat(1, 1, 1'b1); exp_sums.push_back(819200);
    beat(2, 1, 1'b1); exp_sums.push_back(0);
    beat(3, 1, 1'b1); exp_sums.push_back(2097152);
    drain(6);

    // N=2, two consecutive beats.
    gmax = 16'sh0500;
    beat(0, 2, 1'b0);
    beat(0, 2, 1'b1); exp_sums.push_back(4194304);
    drain(6);

    // N=3 with bubbles and a 2-cycle stall mid-group and after the last beat.
    beat(4, 3, 1'b0);
    bubble();
    beat(1, 3, 1'b0);
    stall();
    stall();
    bubble();
    beat(0, 3, 1'b1); exp_sums.push_back(4373504);
    bubble();
    stall();
    drain(8);

    // N=13 whose later beats carry length_mode 1, then immediate short groups
    // including out-of-range modes 0, 15 and 14.
    for (int b = 0; b < 13; b++)
      beat((b % 2) ? 4 : 0, (b == 0) ? 13 : 1, b == 12);
    exp_sums.push_back(23422976);
    beat(1, 1, 1'b1);  exp_sums.push_back(819200);
    beat(0, 0, 1'b1);  exp_sums.push_back(2097152);
    beat(2, 15, 1'b1); exp_sums.push_back(0);
    beat(3, 14, 1'b1); exp_sums.push_back(2097152);
    drain(8);

    // Reset after beat 2 of an N=5 group aborts it.
    beat(0, 5, 1'b0, 1'b0);
    beat(0, 5, 1'b0, 1'b0);
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    drain(6);
    beat(4, 1, 1'b1); exp_sums.push_back(1457152);
    drain(8);
    check("sum_hold", o_sum, 1457152);
    check("sumv_idle", o_sum_valid, 0);

    check("beats_left", exp_beats.size(), 0);
    check("sums_left", exp_sums.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_max_exp2.md
Name: sub_max_exp2

Overview:
- Softmax stage placed directly downstream of the 12-cycle max-forwarding stage.
- Takes each lane element x and its aligned group global max M, and computes d = x − M for each lane.
- Approximates e^d as a base-2 exponential: scale by log2(e), split into integer and fraction parts, apply a linear mantissa, then shift.
- Emits the per-lane exponentials and a per-group sum of all lane exponentials for the downstream reciprocal/normalise stage.

Parameters:
- LANES, 64, number of 16-bit lanes per beat.
- DW, 16, element width in bits: signed Q8.8 input, unsigned Q1.15 output.
- SUMW, 26, sum accumulator width; must be ≥ log2(LANES·13·32768).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_en  in  1  global enable; when 0, every register holds.
- i_valid  in  1  beat valid (the upstream o_valid_max).
- i_global_max  in  16  signed Q8.8 group max, aligned to this beat.
- i_length_mode  in  4  beats per group.
- i_in_flat  in  LANES·16  signed Q8.8 elements; lane i is at [16i+15:16i].
- o_valid  out  1  exp beat valid.
- o_exp_flat  out  LANES·16  unsigned Q1.15 exponentials.
- o_length_mode_byp  out  4  length mode delayed with the beat.
- o_last  out  1  marks the final beat of a group (qualified by o_valid).
- o_sum_valid  out  1  one-cycle pulse when the group sum is ready.
- o_sum  out  SUMW  unsigned sum of all o_exp lanes over the group.

Behaviour:
- Reset: every pipeline register and output is 0; beat counter is 0; accumulator is 0.
- Reset mid-group aborts the group. No o_sum_valid is produced for the aborted group.
- Stalls: i_en = 0 freezes all state, including counters. Outputs are held.
- Group length N = i_length_mode for values 1..13; 0, 14 and 15 are treated as N = 1.
- N is latched on the first valid beat of a group (counter = 0) and ignored on later beats of that group.
- Invalid beats are bubbles: they propagate with o_valid = 0, are not counted, and are not accumulated.
- Beat counter: increments on each valid beat. On the valid beat where counter = N−1, that beat is tagged last and the counter wraps to 0.
- S1 (per lane, registered):
  - d = x − M in 17-bit signed. If d > 0, clamp d to 0 (guards against a mis-aligned max).
  - y = d + (d>>>1) − (d>>>4), 19-bit signed (≈ 1.4375·d, arithmetic shifts).
  - u = −y, 18-bit unsigned.
- S2 (per lane, registered):
  - k = u[17:8], f = u[7:0].
  - m = 32768 − 64·f.
  - e = m >> k if k < 16, otherwise e = 0.
  - e = 32768 exactly when d = 0.
- S3 (registered):
  - o_exp_flat, o_valid, o_last and o_length_mode_byp are presented. Element latency is exactly 3 enabled cycles.
  - A lane adder tree forms beat_sum (22 bits) in the same stage.
- S4 (accumulator):
  - On a valid beat: acc ← (first beat of group ? 0 : acc) + beat_sum.
  - On a last beat: o_sum ← final total and o_sum_valid pulses. This is 4 enabled cycles after the last beat's input.
  - o_sum holds its value until the next pulse.
- Back-to-back groups with no bubble are supported. The accumulator restarts on the beat right after a last beat, with no lost cycle.
- Overflow cannot occur with SUMW ≥ 26 and N ≤ 13.

Decomposition:
- Package softmax_pkg holds:
  - DW, Q8.8/Q1.15 format constants, EXP_ONE = 16'h8000, LOG2E shift taps (1, 4).
  - MAX_LEN = 13 and the length_mode→N decode function.
- One sub-module exp2_lane holds the S1/S2 per-lane datapath (2 registered stages, enable). It is instantiated LANES times by a generate loop.
- The beat counter, adder tree and accumulator stay in the top module.

Test Plan:
- All lanes x = M = 0x0500, N = 1, single valid beat → after 3 cycles o_exp lanes = 0x8000 and o_last = 1; after 4 cycles o_sum = 64·32768 = 2097152 with o_sum_valid pulsing 1 cycle.
- x = M − 0x0100 (d = −1.0) → u = 368, k = 1, f = 112, m = 25600; o_exp = 12800. With x = M − 0x1000, o_exp = 0. With x = M + 5, o_exp = 0x8000 (clamp).
- length_mode = 2, two consecutive valid beats of all-zero d → o_last only on beat 2; o_sum = 4194304 once.
- length_mode = 3 with bubbles between beats, plus i_en held low 2 cycles mid-group → o_sum equals the sum over exactly 3 valid beats; output timing stretches by the stall cycles; nothing is lost.
- length_mode = 13 followed immediately by length_mode = 1 (changed mid-group, ignored until the next group start) → sums match a golden model for both groups; the second group's N comes from its own first beat.
- Assert i_rst after beat 2 of a length-5 group → all outputs 0 next cycle, no o_sum_valid; a new length-1 group afterwards yields the correct sum.
